// File: rtl/router_port_sched.sv
// Crossbar scheduler for the serial router: per-input address decode FSMs feeding
// per-output round-robin arbiters that stay locked to a winner until its frame ends.
module router_port_sched #(
   parameter int NUM_PORTS = 16,
   parameter int ADDR_W    = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_PORTS-1:0]        frame_n,
   input  logic [NUM_PORTS-1:0]        valid_n,
   input  logic [NUM_PORTS-1:0]        din,
   output logic [NUM_PORTS-1:0]        in_grant,
   output logic [NUM_PORTS-1:0]        out_busy,
   output logic [NUM_PORTS*ADDR_W-1:0] out_src,
   output logic [NUM_PORTS-1:0]        viol
);

   typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, REQ = 2'd2, GRANTED = 2'd3} state_t;

   state_t               state     [NUM_PORTS];
   state_t               state_nxt [NUM_PORTS];
   logic [1:0]           bit_cnt   [NUM_PORTS];
   logic [ADDR_W-1:0]    dest      [NUM_PORTS];
   logic [NUM_PORTS-1:0] req_mat   [NUM_PORTS];
   logic [ADDR_W-1:0]    gnt_idx   [NUM_PORTS];
   logic [ADDR_W-1:0]    src       [NUM_PORTS];
   logic [ADDR_W-1:0]    last      [NUM_PORTS];
   logic [NUM_PORTS-1:0] gnt_vld;
   logic [NUM_PORTS-1:0] won;
   logic [NUM_PORTS-1:0] release_o;
   logic [NUM_PORTS-1:0] busy;

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (reset) state[i] <= IDLE;
         else       state[i] <= state_nxt[i];
      end
   end

   // Address shift-in needs no reset: every frame start rewrites bit 0 and the count.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (state[i] == IDLE) begin
            bit_cnt[i] <= 2'd1;
            dest[i][0] <= din[i];
         end else if (state[i] == ADDR) begin
            bit_cnt[i]          <= bit_cnt[i] + 2'd1;
            dest[i][bit_cnt[i]] <= din[i];
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_PORTS; i++) begin
         state_nxt[i] = state[i];
         case (state[i])
            IDLE:    if (!frame_n[i]) state_nxt[i] = ADDR;
            ADDR:    if (frame_n[i]) state_nxt[i] = IDLE;
                     else if (bit_cnt[i] == 2'd3) state_nxt[i] = REQ;
            REQ:     if (frame_n[i]) state_nxt[i] = IDLE;
                     else if (won[i]) state_nxt[i] = GRANTED;
            GRANTED: if (frame_n[i]) state_nxt[i] = IDLE;
            default: state_nxt[i] = IDLE;
         endcase
      end
   end

   // A request is withdrawn in the same cycle frame_n rises, so an aborting input never wins.
   always_comb begin
      for (int i = 0; i < NUM_PORTS; i++) begin
         in_grant[i] = (state[i] == GRANTED);
      end
      for (int o = 0; o < NUM_PORTS; o++) begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            req_mat[o][i] = (state[i] == REQ) && !frame_n[i] && (dest[i] == ADDR_W'(o));
         end
      end
   end

   always_comb begin
      for (int o = 0; o < NUM_PORTS; o++) begin
         gnt_vld[o] = 1'b0;
         gnt_idx[o] = '0;
         if (!busy[o]) begin
            for (int k = 1; k <= NUM_PORTS; k++) begin
               if (!gnt_vld[o] && req_mat[o][last[o] + ADDR_W'(k)]) begin
                  gnt_vld[o] = 1'b1;
                  gnt_idx[o] = last[o] + ADDR_W'(k);
               end
            end
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_PORTS; i++) begin
         won[i] = 1'b0;
         for (int o = 0; o < NUM_PORTS; o++) begin
            if (gnt_vld[o] && gnt_idx[o] == ADDR_W'(i)) won[i] = 1'b1;
         end
      end
      for (int o = 0; o < NUM_PORTS; o++) begin
         release_o[o] = busy[o] && frame_n[src[o]];
         out_src[o*ADDR_W +: ADDR_W] = src[o];
      end
   end

   // Release and grant never collide on one output: arbitration only runs while not busy.
   always_ff @(posedge clk) begin
      if (reset) begin
         busy <= '0;
         viol <= '0;
         for (int o = 0; o < NUM_PORTS; o++) begin
            src[o]  <= '0;
            last[o] <= ADDR_W'(NUM_PORTS - 1);
         end
      end else begin
         viol <= ~valid_n & ~in_grant;
         for (int o = 0; o < NUM_PORTS; o++) begin
            if (release_o[o]) begin
               busy[o] <= 1'b0;
               src[o]  <= '0;
            end else if (gnt_vld[o]) begin
               busy[o] <= 1'b1;
               src[o]  <= gnt_idx[o];
               last[o] <= gnt_idx[o];
            end
         end
      end
   end

   assign out_busy = busy;

endmodule

// File: tb/tb_router_port_sched.sv
// Bench for router_port_sched: frame-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_router_port_sched;
   localparam int N  = 16;
   localparam int AW = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic [N-1:0]     frame_n, valid_n, din;
   logic [N-1:0]     in_grant, out_busy, viol;
   logic [N*AW-1:0]  out_src;

   always #5 clk = ~clk;

   router_port_sched #(.NUM_PORTS(N), .ADDR_W(AW)) dut (
      .clk(clk), .reset(reset), .frame_n(frame_n), .valid_n(valid_n), .din(din),
      .in_grant(in_grant), .out_busy(out_busy), .out_src(out_src), .viol(viol)
   );

   // Reference model: owner per output, collected address bits per input.
   int          m_owner [N];
   int          m_last  [N];
   int          m_nbits [N];
   int          m_win   [N];
   int          m_p;
   logic [AW-1:0] m_addr [N];
   bit          m_owns  [N];
   bit          m_viol  [N];

   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N; i++) begin
            m_owner[i] = -1; m_last[i] = N - 1; m_nbits[i] = 0;
            m_addr[i] = '0; m_owns[i] = 0; m_viol[i] = 0;
         end
      end else begin
         for (int o = 0; o < N; o++) begin
            m_win[o] = -1;
            if (m_owner[o] < 0) begin
               for (int k = 1; k <= N; k++) begin
                  m_p = (m_last[o] + k) % N;
                  if (m_win[o] < 0 && m_nbits[m_p] == 4 && !m_owns[m_p] &&
                      frame_n[m_p] == 1'b0 && int'(m_addr[m_p]) == o)
                     m_win[o] = m_p;
               end
            end
         end
         for (int i = 0; i < N; i++) m_viol[i] = (valid_n[i] == 1'b0) && !m_owns[i];
         for (int o = 0; o < N; o++) begin
            if (m_owner[o] >= 0 && frame_n[m_owner[o]]) m_owner[o] = -1;
            else if (m_win[o] >= 0) begin
               m_owner[o] = m_win[o];
               m_last[o]  = m_win[o];
            end
         end
         for (int i = 0; i < N; i++) begin
            if (frame_n[i]) begin
               m_nbits[i] = 0; m_owns[i] = 0; m_addr[i] = '0;
            end else if (!m_owns[i]) begin
               if (m_nbits[i] < 4) begin
                  m_addr[i][m_nbits[i]] = din[i];
                  m_nbits[i]++;
               end else if (m_win[m_addr[i]] == i) m_owns[i] = 1;
            end
         end
      end
   end

   // Stimulus engine: drives frames mid-cycle, payload starts once the model owns the output.
   int            req_seq [N] = '{default: 0};
   int            ack_seq [N] = '{default: 0};
   logic [AW-1:0] d_addr [N];
   int            d_pay [N], d_abort [N];
   bit            d_viol [N];
   bit            rnd_mode = 0;
   logic [AW-1:0] e_addr [N];
   int            e_pay [N], e_abort [N], ph [N], bitn [N];
   bit            e_viol [N];

   always @(posedge clk) begin
      #2;
      for (int i = 0; i < N; i++) begin
         if (reset) begin
            ph[i] = 0; frame_n[i] = 1'b1; valid_n[i] = 1'b1; din[i] = 1'b0;
         end else begin
            case (ph[i])
               0: begin
                  frame_n[i] = 1'b1;
                  din[i]     = 1'($urandom_range(0, 1));
                  valid_n[i] = (rnd_mode && $urandom_range(0, 7) == 0) ? 1'b0 : 1'b1;
                  if (req_seq[i] != ack_seq[i]) begin
                     ack_seq[i] = req_seq[i];
                     e_addr[i] = d_addr[i]; e_pay[i] = d_pay[i];
                     e_abort[i] = d_abort[i]; e_viol[i] = d_viol[i]; ph[i] = 1;
                  end else if (rnd_mode && $urandom_range(0, 4) == 0) begin
                     case ($urandom_range(0, 3))
                        0:       e_addr[i] = 4'd7;
                        1:       e_addr[i] = 4'd9;
                        default: e_addr[i] = 4'($urandom_range(0, 15));
                     endcase
                     e_pay[i]   = $urandom_range(1, 5);
                     e_abort[i] = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 9;
                     e_viol[i]  = ($urandom_range(0, 2) == 0);
                     ph[i] = 1;
                  end
                  if (ph[i] == 1) begin
                     frame_n[i] = 1'b0; valid_n[i] = 1'b1; din[i] = e_addr[i][0]; bitn[i] = 1;
                  end
               end
               1: begin
                  valid_n[i] = 1'b1;
                  if (bitn[i] == e_abort[i]) begin
                     frame_n[i] = 1'b1; ph[i] = 0;
                  end else begin
                     frame_n[i] = 1'b0; din[i] = e_addr[i][bitn[i]];
                     if (bitn[i] == 3) ph[i] = 2;
                     else bitn[i]++;
                  end
               end
               default: begin
                  din[i] = 1'($urandom_range(0, 1));
                  if (m_owns[i]) begin
                     valid_n[i] = 1'b0;
                     if (e_pay[i] <= 1) begin
                        frame_n[i] = 1'b1; ph[i] = 0;
                     end else begin
                        frame_n[i] = 1'b0; e_pay[i]--;
                     end
                  end else begin
                     frame_n[i] = 1'b0;
                     valid_n[i] = e_viol[i] ? 1'b0 : 1'b1;
                     if (rnd_mode && $urandom_range(0, 63) == 0) begin
                        frame_n[i] = 1'b1; ph[i] = 0;
                     end
                  end
               end
            endcase
         end
      end
   end

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   task automatic model_cmp();
      logic [N-1:0]    eg, eb, ev;
      logic [N*AW-1:0] es;
      for (int i = 0; i < N; i++) begin
         eg[i] = m_owns[i];
         ev[i] = m_viol[i];
         eb[i] = (m_owner[i] >= 0);
         es[i*AW +: AW] = (m_owner[i] >= 0) ? AW'(m_owner[i]) : '0;
      end
      chk("mdl_in_grant", 64'(in_grant), 64'(eg));
      chk("mdl_out_busy", 64'(out_busy), 64'(eb));
      chk("mdl_out_src",  64'(out_src),  64'(es));
      chk("mdl_viol",     64'(viol),     64'(ev));
   endtask

   task automatic step(input logic r);
      @(posedge clk);
      #1 reset = r;
      @(negedge clk);
      model_cmp();
   endtask

   task automatic launch(input int i, input int a, input int pay, input int ab, input bit vl);
      d_addr[i] = AW'(a); d_pay[i] = pay; d_abort[i] = ab; d_viol[i] = vl;
      req_seq[i]++;
   endtask

   function automatic logic [AW-1:0] src_of(input int o);
      return out_src[o*AW +: AW];
   endfunction

   initial begin
      bit eb;
      reset = 1'b1;
      repeat (3) step(1'b1);
      chk("rst_in_grant", 64'(in_grant), 64'd0);
      chk("rst_out_busy", 64'(out_busy), 64'd0);
      chk("rst_out_src",  64'(out_src),  64'd0);
      chk("rst_viol",     64'(viol),     64'd0);
      repeat (2) step(1'b0);

      launch(3, 9, 3, 9, 0);
      for (int c = 0; c < 10; c++) begin
         step(1'b0);
         if (c == 4) chk("single_pre_grant", 64'(in_grant[3]), 64'd0);
         if (c == 5) begin
            chk("single_grant", 64'(in_grant[3]), 64'd1);
            chk("single_busy",  64'(out_busy[9]), 64'd1);
            chk("single_src",   64'(src_of(9)),   64'd3);
         end
         if (c == 7) chk("single_last_busy", 64'(out_busy[9]), 64'd1);
         if (c == 8) chk("single_release", 64'({out_busy[9], in_grant[3]}), 64'd0);
      end

      launch(2, 7, 3, 9, 0); launch(5, 7, 3, 9, 0); launch(14, 7, 3, 9, 0);
      for (int c = 0; c < 18; c++) begin
         step(1'b0);
         eb = (c >= 5 && c <= 7) || (c >= 9 && c <= 11) || (c >= 13 && c <= 15);
         chk("cont_busy", 64'(out_busy[7]), 64'(eb));
         if (eb) chk("cont_src", 64'(src_of(7)), (c <= 7) ? 64'd2 : (c <= 11) ? 64'd5 : 64'd14);
      end

      launch(0, 7, 1, 9, 0); launch(15, 7, 1, 9, 0);
      for (int c = 0; c < 10; c++) begin
         step(1'b0);
         if (c == 5) chk("rr_first", 64'({out_busy[7], src_of(7)}), 64'h1F);
         if (c == 6) chk("rr_gap", 64'(out_busy[7]), 64'd0);
         if (c == 7) chk("rr_second", 64'({out_busy[7], src_of(7)}), 64'h10);
      end

      launch(0, 1, 2, 9, 0); launch(1, 2, 2, 9, 0);
      for (int c = 0; c < 9; c++) begin
         step(1'b0);
         if (c == 5) begin
            chk("par_grant", 64'(in_grant[1:0]), 64'd3);
            chk("par_busy",  64'(out_busy[2:1]), 64'd3);
            chk("par_src",   64'(out_src[11:4]), 64'h10);
         end
      end

      launch(4, 5, 3, 2, 0); launch(6, 10, 2, 9, 1);
      for (int c = 0; c < 9; c++) begin
         step(1'b0);
         chk("abort_no_grant", 64'({in_grant[4], out_busy[5]}), 64'd0);
         if (c == 4) chk("viol_before", 64'(viol[6]), 64'd0);
         if (c == 5) chk("viol_pulse",  64'(viol[6]), 64'd1);
         if (c == 6) chk("viol_after",  64'(viol[6]), 64'd0);
      end

      launch(3, 9, 10, 9, 0);
      for (int c = 0; c < 6; c++) step(1'b0);
      chk("rstmid_locked", 64'({out_busy[9], src_of(9)}), 64'h13);
      step(1'b1);
      step(1'b1);
      chk("rstmid_busy",  64'(out_busy), 64'd0);
      chk("rstmid_grant", 64'(in_grant), 64'd0);
      chk("rstmid_src",   64'(out_src),  64'd0);
      repeat (3) step(1'b0);
      launch(8, 9, 2, 9, 0); launch(3, 9, 2, 9, 0);
      for (int c = 0; c < 10; c++) begin
         step(1'b0);
         if (c == 5) chk("rstmid_lowest", 64'({out_busy[9], src_of(9)}), 64'h13);
      end

      rnd_mode = 1;
      for (int c = 0; c < 4000; c++) step(($urandom_range(0, 399) == 0) ? 1'b1 : 1'b0);
      rnd_mode = 0;
      repeat (40) step(1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
